// File: rtl/axi4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_pkg
//  Purpose  : AXI4 burst/response encodings and 4 KB page constants.
//  Revision : 1.0
// ============================================================================
package axi4_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int PAGE_BYTES = 4096;
    localparam int PAGE_BITS  = 12;

endpackage
`default_nettype wire

// File: rtl/axi4_page_fit.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_page_fit
//  Purpose  : Beats of the next INCR sub-burst that fit before the page end.
//  Revision : 1.0
// ============================================================================
module axi4_page_fit
    import axi4_pkg::*;
(
    input  logic [11:0] addr,
    input  logic [2:0]  size,
    input  logic [8:0]  beats_left,
    output logic [8:0]  sub,
    output logic [12:0] next_addr
);

    logic [11:0] w_mask;
    logic [11:0] w_aligned;
    logic [12:0] w_fit;

    assign w_mask    = ~((12'd1 << size) - 12'd1);
    assign w_aligned = addr & w_mask;
    // 13 bits so a fully aligned page start (4096 bytes of room) is representable
    assign w_fit     = (13'(PAGE_BYTES) - {1'b0, w_aligned}) >> size;

    always_comb begin
        sub = beats_left;
        if ({4'b0000, beats_left} > w_fit) begin
            sub = w_fit[8:0];
        end
    end

    // Never exceeds 4096, so the 13-bit sum cannot overflow
    assign next_addr = {1'b0, w_aligned} + ({4'b0000, sub} << size);

endmodule
`default_nettype wire

// File: rtl/axi4_rd_burst_splitter.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_rd_burst_splitter
//  Purpose  : Splits 4 KB-crossing INCR reads, merges R beats into one burst.
//  Revision : 1.0
// ============================================================================
module axi4_rd_burst_splitter
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic [ID_WIDTH-1:0]   s_arid,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic [1:0]            s_arburst,
    input  logic                  s_arlock,
    input  logic [3:0]            s_arcache,
    input  logic [2:0]            s_arprot,
    input  logic [3:0]            s_arqos,
    input  logic [USER_WIDTH-1:0] s_aruser,
    input  logic                  s_arvalid,
    output logic                  s_arready,

    output logic [ID_WIDTH-1:0]   s_rid,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic [USER_WIDTH-1:0] s_ruser,
    output logic                  s_rvalid,
    input  logic                  s_rready,

    output logic [ID_WIDTH-1:0]   m_arid,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arlock,
    output logic [3:0]            m_arcache,
    output logic [2:0]            m_arprot,
    output logic [3:0]            m_arqos,
    output logic [USER_WIDTH-1:0] m_aruser,
    output logic                  m_arvalid,
    input  logic                  m_arready,

    input  logic [ID_WIDTH-1:0]   m_rid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic [USER_WIDTH-1:0] m_ruser,
    input  logic                  m_rvalid,
    output logic                  m_rready,

    output logic                  busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_init;

    logic [ID_WIDTH-1:0]   r_id;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_lock;
    logic [3:0]            r_cache;
    logic [2:0]            r_prot;
    logic [3:0]            r_qos;
    logic [USER_WIDTH-1:0] r_user;
    logic [ADDR_WIDTH-1:0] r_addr_cur;
    logic [8:0]            r_beats_left;
    logic [8:0]            r_beat_cnt;

    logic [8:0]            w_sub;
    logic [8:0]            w_sub_m1;
    logic [12:0]           w_next_off;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_is_incr;
    logic                  w_active;
    logic                  w_ar_hs;
    logic                  w_m_ar_hs;
    logic                  w_r_hs;
    logic                  w_last_hs;
    logic                  w_ar_done;
    logic                  w_unused;

    axi4_page_fit u_page_fit (
        .addr       (r_addr_cur[PAGE_BITS-1:0]),
        .size       (r_size),
        .beats_left (r_beats_left),
        .sub        (w_sub),
        .next_addr  (w_next_off)
    );

    // Page base of the current address plus the in-page offset of the next beat
    assign w_next_addr = {r_addr_cur[ADDR_WIDTH-1:PAGE_BITS], {PAGE_BITS{1'b0}}}
                       + {{(ADDR_WIDTH-13){1'b0}}, w_next_off};

    assign w_is_incr = (r_burst == AXI_BURST_INCR);
    assign w_sub_m1  = w_sub - 9'd1;
    assign w_active  = (r_state == S_ISSUE) || (r_state == S_DRAIN);

    // Upstream AR side
    assign s_arready = r_init && (r_state == S_IDLE);
    assign busy      = w_active;

    // Downstream AR side
    assign m_arvalid = (r_state == S_ISSUE);
    assign m_arid    = r_id;
    assign m_araddr  = r_addr_cur;
    assign m_arlen   = w_is_incr ? w_sub_m1[7:0] : r_len;
    assign m_arsize  = r_size;
    assign m_arburst = r_burst;
    assign m_arlock  = r_lock;
    assign m_arcache = r_cache;
    assign m_arprot  = r_prot;
    assign m_arqos   = r_qos;
    assign m_aruser  = r_user;

    // R path: zero-latency pass-through; RLAST regenerated from the beat count
    assign s_rvalid  = w_active && m_rvalid;
    assign m_rready  = w_active && s_rready;
    assign s_rid     = m_rid;
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_ruser   = m_ruser;
    assign s_rlast   = s_rvalid && (r_beat_cnt == {1'b0, r_len});
    assign w_unused  = m_rlast;

    assign w_ar_hs   = s_arvalid && s_arready;
    assign w_m_ar_hs = m_arvalid && m_arready;
    assign w_r_hs    = s_rvalid && s_rready;
    assign w_last_hs = w_r_hs && s_rlast;
    assign w_ar_done = w_m_ar_hs && (!w_is_incr || (r_beats_left == w_sub));

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ar_hs) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_last_hs) begin
                    w_state_nxt = S_IDLE;
                end else if (w_ar_done) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_init       <= 1'b0;
            r_id         <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= '0;
            r_lock       <= 1'b0;
            r_cache      <= '0;
            r_prot       <= '0;
            r_qos        <= '0;
            r_user       <= '0;
            r_addr_cur   <= '0;
            r_beats_left <= '0;
            r_beat_cnt   <= '0;
        end else begin
            r_init <= 1'b1;
            if (w_ar_hs) begin
                r_id         <= s_arid;
                r_len        <= s_arlen;
                r_size       <= s_arsize;
                r_burst      <= s_arburst;
                r_lock       <= s_arlock;
                r_cache      <= s_arcache;
                r_prot       <= s_arprot;
                r_qos        <= s_arqos;
                r_user       <= s_aruser;
                r_addr_cur   <= s_araddr;
                r_beats_left <= {1'b0, s_arlen} + 9'd1;
                r_beat_cnt   <= '0;
            end
            if (w_m_ar_hs) begin
                r_beats_left <= w_is_incr ? (r_beats_left - w_sub) : 9'd0;
                r_addr_cur   <= w_next_addr;
            end
            if (w_r_hs) begin
                r_beat_cnt <= r_beat_cnt + 9'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_rd_burst_splitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_rd_burst_splitter
//  Purpose  : Randomized self-checking bench with a beat-address page model.
//  Revision : 1.0
// ============================================================================
module tb_axi4_rd_burst_splitter;
    import axi4_pkg::*;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int IW = 4;
    localparam int UW = 1;

    logic          aclk;
    logic          areset;
    logic [IW-1:0] s_arid;
    logic [AW-1:0] s_araddr;
    logic [7:0]    s_arlen;
    logic [2:0]    s_arsize;
    logic [1:0]    s_arburst;
    logic          s_arlock;
    logic [3:0]    s_arcache;
    logic [2:0]    s_arprot;
    logic [3:0]    s_arqos;
    logic [UW-1:0] s_aruser;
    logic          s_arvalid;
    logic          s_arready;
    logic [IW-1:0] s_rid;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rlast;
    logic [UW-1:0] s_ruser;
    logic          s_rvalid;
    logic          s_rready;
    logic [IW-1:0] m_arid;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_arlock;
    logic [3:0]    m_arcache;
    logic [2:0]    m_arprot;
    logic [3:0]    m_arqos;
    logic [UW-1:0] m_aruser;
    logic          m_arvalid;
    logic          m_arready;
    logic [IW-1:0] m_rid;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rlast;
    logic [UW-1:0] m_ruser;
    logic          m_rvalid;
    logic          m_rready;
    logic          busy;

    int checks;
    int failures;

    logic [AW-1:0] exp_addr[$];
    logic [7:0]    exp_len[$];

    axi4_rd_burst_splitter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .USER_WIDTH (UW)
    ) dut (
        .aclk      (aclk),      .areset    (areset),
        .s_arid    (s_arid),    .s_araddr  (s_araddr),  .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),  .s_arburst (s_arburst), .s_arlock  (s_arlock),
        .s_arcache (s_arcache), .s_arprot  (s_arprot),  .s_arqos   (s_arqos),
        .s_aruser  (s_aruser),  .s_arvalid (s_arvalid), .s_arready (s_arready),
        .s_rid     (s_rid),     .s_rdata   (s_rdata),   .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),   .s_ruser   (s_ruser),   .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .m_arid    (m_arid),    .m_araddr  (m_araddr),  .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),  .m_arburst (m_arburst), .m_arlock  (m_arlock),
        .m_arcache (m_arcache), .m_arprot  (m_arprot),  .m_arqos   (m_arqos),
        .m_aruser  (m_aruser),  .m_arvalid (m_arvalid), .m_arready (m_arready),
        .m_rid     (m_rid),     .m_rdata   (m_rdata),   .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),   .m_ruser   (m_ruser),   .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),  .busy      (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Reference: walk every beat address, start a new downstream burst when the page changes
    function automatic void build_exp(input logic [AW-1:0] addr, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
        logic [AW-1:0] aligned;
        logic [AW-1:0] a;
        logic [AW-1:0] grp_addr;
        int            count;
        exp_addr.delete();
        exp_len.delete();
        if (burst != AXI_BURST_INCR) begin
            exp_addr.push_back(addr);
            exp_len.push_back(len);
            return;
        end
        aligned  = (addr >> size) << size;
        grp_addr = addr;
        count    = 0;
        for (int i = 0; i <= int'(len); i++) begin
            a = (i == 0) ? addr : aligned + (AW'(i) << size);
            if ((a >> 12) != (grp_addr >> 12)) begin
                exp_addr.push_back(grp_addr);
                exp_len.push_back(8'(count - 1));
                grp_addr = a;
                count    = 0;
            end
            count++;
        end
        exp_addr.push_back(grp_addr);
        exp_len.push_back(8'(count - 1));
    endfunction

    task automatic recover_reset();
        @(negedge aclk);
        areset = 1'b1; s_arvalid = 1'b0; m_rvalid = 1'b0; m_arready = 1'b0; s_rready = 1'b0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
    endtask

    // One full upstream transaction: AR issue phase, then R merge phase
    task automatic do_txn(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int err_beat, input bit toggle_rready);
        logic [IW-1:0] id;
        logic [UW-1:0] user;
        logic [3:0]    cache;
        logic [3:0]    qos;
        logic [2:0]    prot;
        logic          lock;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        int            got;
        int            cyc;
        int            b;
        int            n;
        bit            timeout;
        id = IW'($urandom); user = UW'($urandom); cache = 4'($urandom);
        qos = 4'($urandom); prot = 3'($urandom); lock = 1'($urandom);
        timeout = 1'b0;
        build_exp(addr, len, size, burst);
        n = exp_addr.size();

        @(negedge aclk);
        s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
        s_arlock = lock; s_arcache = cache; s_arprot = prot; s_arqos = qos; s_aruser = user;
        s_arvalid = 1'b1;
        #1;
        checks++;
        if (s_arready !== 1'b1) begin
            failures++;
            $display("FAIL s_arready_idle: got %b exp 1", s_arready);
        end
        @(negedge aclk);
        s_arvalid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || m_arvalid !== 1'b1) begin
            failures++;
            $display("FAIL ar_latency: busy=%b m_arvalid=%b exp 1 1", busy, m_arvalid);
        end

        got = 0; cyc = 0;
        while (got < n && cyc < 50 * n + 50) begin
            m_arready = toggle_rready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (m_arvalid && m_arready) begin
                checks++;
                if (m_araddr !== exp_addr[got]) begin
                    failures++;
                    $display("FAIL ar_addr[%0d]: got %h exp %h", got, m_araddr, exp_addr[got]);
                end
                checks++;
                if (m_arlen !== exp_len[got]) begin
                    failures++;
                    $display("FAIL ar_len[%0d]: got %0d exp %0d", got, m_arlen, exp_len[got]);
                end
                checks++;
                if ({m_arid, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos, m_aruser}
                    !== {id, size, burst, lock, cache, prot, qos, user}) begin
                    failures++;
                    $display("FAIL ar_attr[%0d]: got %h exp %h", got,
                        {m_arid, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos, m_aruser},
                        {id, size, burst, lock, cache, prot, qos, user});
                end
                got++;
            end
            @(negedge aclk);
            cyc++;
        end
        m_arready = 1'b0;
        #1;
        checks++;
        if (got != n || m_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL ar_count: got %0d ars (m_arvalid=%b) exp %0d", got, m_arvalid, n);
            timeout = 1'b1;
        end

        b = 0; cyc = 0;
        while (!timeout && b <= int'(len) && cyc < 4 * (int'(len) + 1) + 50) begin
            data = {$urandom, $urandom, $urandom, $urandom};
            resp = (b == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            m_rvalid = 1'b1; m_rdata = data; m_rresp = resp; m_rid = id; m_ruser = user;
            m_rlast  = 1'($urandom);
            s_rready = toggle_rready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            checks++;
            if (s_rvalid !== 1'b1 || m_rready !== s_rready) begin
                failures++;
                $display("FAIL r_handshake[%0d]: s_rvalid=%b m_rready=%b exp 1 %b", b, s_rvalid, m_rready, s_rready);
            end
            checks++;
            if ({s_rid, s_rdata, s_rresp, s_ruser} !== {id, data, resp, user}) begin
                failures++;
                $display("FAIL r_payload[%0d]: got resp %0d id %h exp resp %0d id %h", b, s_rresp, s_rid, resp, id);
            end
            checks++;
            if (s_rlast !== (b == int'(len))) begin
                failures++;
                $display("FAIL r_last[%0d]: got %b exp %b", b, s_rlast, (b == int'(len)));
            end
            if (s_rready) b++;
            @(negedge aclk);
            cyc++;
        end
        m_rvalid = 1'b0; s_rready = 1'b0;
        #1;
        checks++;
        if (timeout || b != int'(len) + 1 || busy !== 1'b0 || s_arready !== 1'b1) begin
            failures++;
            $display("FAIL txn_end: beats %0d busy=%b s_arready=%b exp %0d 0 1", b, busy, s_arready, int'(len) + 1);
            recover_reset();
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        #1;
        checks++;
        if (s_arready !== 1'b0 || m_arvalid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: arready=%b arvalid=%b busy=%b exp 0 0 0", s_arready, m_arvalid, busy);
        end
        @(negedge aclk);
        areset = 1'b0;
        #1;
        checks++;
        if (s_arready !== 1'b0) begin
            failures++;
            $display("FAIL arready_early: got %b exp 0", s_arready);
        end
        @(negedge aclk);
        #1;
        checks++;
        if (s_arready !== 1'b1) begin
            failures++;
            $display("FAIL arready_after_reset: got %b exp 1", s_arready);
        end
    endtask

    task automatic test_idle_gating();
        @(negedge aclk);
        m_rvalid = 1'b1; s_rready = 1'b1;
        #1;
        checks++;
        if (s_rvalid !== 1'b0 || m_rready !== 1'b0) begin
            failures++;
            $display("FAIL idle_gating: s_rvalid=%b m_rready=%b exp 0 0", s_rvalid, m_rready);
        end
        m_rvalid = 1'b0; s_rready = 1'b0;
    endtask

    task automatic test_directed();
        do_txn(32'h0000_0FF8, 8'd3,   3'd3, AXI_BURST_INCR,  -1, 1'b0);
        do_txn(32'h0000_1000, 8'd255, 3'd4, AXI_BURST_INCR,  -1, 1'b0);
        do_txn(32'h0000_0FFD, 8'd1,   3'd2, AXI_BURST_INCR,  -1, 1'b1);
        do_txn(32'h0000_0FF0, 8'd3,   3'd3, AXI_BURST_WRAP,  -1, 1'b1);
        do_txn(32'h0000_0FF8, 8'd7,   3'd3, AXI_BURST_FIXED, -1, 1'b1);
        do_txn(32'h0000_2000, 8'd0,   3'd0, AXI_BURST_INCR,  -1, 1'b0);
    endtask

    task automatic test_slverr();
        do_txn(32'h0000_3FF0, 8'd5, 3'd3, AXI_BURST_INCR, 1, 1'b1);
    endtask

    task automatic test_random();
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        int            sel;
        for (int t = 0; t < 30; t++) begin
            size = 3'($urandom_range(0, 4));
            addr = {12'($urandom_range(0, 4000)), 8'($urandom), 12'd0};
            addr = addr + (($urandom_range(0, 1) == 1) ? AW'(4096 - $urandom_range(1, 600)) : AW'($urandom_range(0, 4095)));
            len  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
            sel  = $urandom_range(0, 9);
            burst = AXI_BURST_INCR;
            if (sel == 0) burst = AXI_BURST_FIXED;
            if (sel == 1) begin
                burst = AXI_BURST_WRAP;
                len   = 8'((2 << $urandom_range(0, 3)) - 1);
                addr  = (addr >> size) << size;
            end
            do_txn(addr, len, size, burst,
                   ($urandom_range(0, 1) == 1) ? $urandom_range(0, int'(len)) : -1, 1'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        @(negedge aclk);
        s_araddr = 32'h0000_5FC0; s_arlen = 8'd15; s_arsize = 3'd3; s_arburst = AXI_BURST_INCR;
        s_arvalid = 1'b1; m_arready = 1'b0;
        @(negedge aclk);
        s_arvalid = 1'b0;
        #1;
        checks++;
        if (m_arvalid !== 1'b1) begin
            failures++;
            $display("FAIL mid_issue: m_arvalid=%b exp 1", m_arvalid);
        end
        areset = 1'b1;
        @(negedge aclk);
        #1;
        checks++;
        if (m_arvalid !== 1'b0 || busy !== 1'b0 || s_arready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: arvalid=%b busy=%b arready=%b exp 0 0 0", m_arvalid, busy, s_arready);
        end
        areset = 1'b0;
        @(negedge aclk);
        #1;
        checks++;
        if (s_arready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_release: arready=%b busy=%b exp 1 0", s_arready, busy);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        areset = 1'b1;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        s_arlock = 1'b0; s_arcache = '0; s_arprot = '0; s_arqos = '0; s_aruser = '0;
        s_arvalid = 1'b0; s_rready = 1'b0; m_arready = 1'b0;
        m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_ruser = '0; m_rvalid = 1'b0;

        test_reset();
        test_idle_gating();
        test_directed();
        test_slverr();
        test_random();
        test_reset_mid();
        do_txn(32'h0000_7FF8, 8'd2, 3'd3, AXI_BURST_INCR, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
